// File: rtl/upsp_lane_pkg.sv
// upsp_lane_pkg: shared FSM state type and derived-size helpers
// for the multi-lane bicubic upsample dispatcher.
package upsp_lane_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int PIX_BITS = 24;

    function automatic int cnt_w(input int range);
        return (range <= 1) ? 1 : $clog2(range);
    endfunction

    function automatic int block_w(input int src_w, input int lanes);
        return src_w / lanes;
    endfunction

    function automatic int out_beats(
        input int src_w,
        input int lanes,
        input int scale,
        input int wr_w
    );
        return block_w(src_w, lanes) * scale / (wr_w / PIX_BITS);
    endfunction

endpackage

// File: rtl/upsp_lane_cnt.sv
// upsp_lane_cnt: three-level nested wrap counter (inner/mid/outer),
// exposing the mid level and a last-position flag.
module upsp_lane_cnt
    import upsp_lane_pkg::*;
#(
    parameter int INNER = 4,
    parameter int MID = 4,
    parameter int OUTER = 4,
    localparam int IW = cnt_w(INNER),
    localparam int MW = cnt_w(MID),
    localparam int OW = cnt_w(OUTER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [MW-1:0] mid_q,
    output logic          last
);

    localparam logic [IW-1:0] I_MAX = IW'(INNER - 1);
    localparam logic [MW-1:0] M_MAX = MW'(MID - 1);
    localparam logic [OW-1:0] O_MAX = OW'(OUTER - 1);

    logic [IW-1:0] inner_q;
    logic [OW-1:0] outer_q;
    logic          inner_wrap;
    logic          mid_wrap;
    logic          outer_wrap;

    assign inner_wrap = (inner_q == I_MAX);
    assign mid_wrap   = (mid_q == M_MAX);
    assign outer_wrap = (outer_q == O_MAX);
    assign last       = inner_wrap && mid_wrap && outer_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inner_q <= '0;
            mid_q   <= '0;
            outer_q <= '0;
        end else if (clr) begin
            inner_q <= '0;
            mid_q   <= '0;
            outer_q <= '0;
        end else if (inc) begin
            inner_q <= inner_wrap ? '0 : inner_q + 1'b1;
            if (inner_wrap) begin
                mid_q <= mid_wrap ? '0 : mid_q + 1'b1;
                if (mid_wrap) begin
                    outer_q <= outer_wrap ? '0 : outer_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/upsp_lane_dispatcher.sv
// upsp_lane_dispatcher: splits the source pixel stream into vertical
// column blocks per PE lane and re-serialises lane output in raster order.
module upsp_lane_dispatcher
    import upsp_lane_pkg::*;
#(
    parameter int NUM_LANES          = 4,
    parameter int UPSP_RDDATA_WIDTH  = 24,
    parameter int UPSP_WRTDATA_WIDTH = 96,
    parameter int SRC_IMG_WIDTH      = 960,
    parameter int SRC_IMG_HEIGHT     = 540,
    parameter int SCALE              = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    frame_start,
    output logic                                    busy,
    output logic                                    frame_done,
    input  logic                                    ac_upsp_rvalid,
    input  logic [UPSP_RDDATA_WIDTH-1:0]            ac_upsp_rdata,
    output logic                                    upsp_ac_rready,
    output logic [NUM_LANES-1:0]                    lane_rvalid,
    output logic [NUM_LANES*UPSP_RDDATA_WIDTH-1:0]  lane_rdata,
    input  logic [NUM_LANES-1:0]                    lane_rready,
    input  logic [NUM_LANES-1:0]                    lane_wvalid,
    input  logic [NUM_LANES*UPSP_WRTDATA_WIDTH-1:0] lane_wdata,
    output logic [NUM_LANES-1:0]                    lane_wready,
    output logic                                    upsp_ac_wvalid,
    output logic [UPSP_WRTDATA_WIDTH-1:0]           upsp_ac_wdata,
    input  logic                                    ac_upsp_wready
);

    localparam int BLOCK_W = block_w(SRC_IMG_WIDTH, NUM_LANES);
    localparam int OUT_BEATS = out_beats(SRC_IMG_WIDTH, NUM_LANES,
                                         SCALE, UPSP_WRTDATA_WIDTH);
    localparam int OUT_ROWS = SRC_IMG_HEIGHT * SCALE;
    localparam int LW = cnt_w(NUM_LANES);
    localparam int WW = UPSP_WRTDATA_WIDTH;

    state_e        state;
    state_e        state_nx;
    logic          in_done;
    logic          in_done_nx;
    logic          out_done;
    logic          out_done_nx;
    logic [LW-1:0] in_lane;
    logic [LW-1:0] out_lane;
    logic          in_last;
    logic          out_last;
    logic          in_act;
    logic          out_act;
    logic          in_hs;
    logic          out_hs;
    logic          clr;

    assign clr     = (state == IDLE);
    assign in_act  = (state == RUN) && !in_done;
    assign out_act = ((state == RUN) || (state == DRAIN)) && !out_done;
    assign in_hs   = in_act && ac_upsp_rvalid && upsp_ac_rready;
    assign out_hs  = out_act && upsp_ac_wvalid && ac_upsp_wready;

    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = (state == DONE);
    assign lane_rdata = {NUM_LANES{ac_upsp_rdata}};

    always_comb begin
        lane_rvalid    = '0;
        lane_wready    = '0;
        upsp_ac_rready = 1'b0;
        upsp_ac_wvalid = 1'b0;
        upsp_ac_wdata  = lane_wdata[WW-1:0];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (out_lane == LW'(i)) begin
                upsp_ac_wdata = lane_wdata[i*WW +: WW];
            end
        end
        if (in_act) begin
            lane_rvalid[in_lane] = ac_upsp_rvalid;
            upsp_ac_rready       = lane_rready[in_lane];
        end
        if (out_act) begin
            upsp_ac_wvalid        = lane_wvalid[out_lane];
            lane_wready[out_lane] = ac_upsp_wready;
        end
    end

    // done flags let either side finish first without the FSM tracking order
    always_comb begin
        state_nx    = state;
        in_done_nx  = in_done || (in_hs && in_last);
        out_done_nx = out_done || (out_hs && out_last);
        unique case (state)
            IDLE: begin
                in_done_nx  = 1'b0;
                out_done_nx = 1'b0;
                if (frame_start) state_nx = RUN;
            end
            RUN: begin
                if (in_done_nx) begin
                    state_nx = out_done_nx ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_done_nx) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_done  <= 1'b0;
            out_done <= 1'b0;
        end else begin
            state    <= state_nx;
            in_done  <= in_done_nx;
            out_done <= out_done_nx;
        end
    end

    upsp_lane_cnt #(
        .INNER(BLOCK_W),
        .MID  (NUM_LANES),
        .OUTER(SRC_IMG_HEIGHT)
    ) u_in_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (in_hs),
        .mid_q(in_lane),
        .last (in_last)
    );

    upsp_lane_cnt #(
        .INNER(OUT_BEATS),
        .MID  (NUM_LANES),
        .OUTER(OUT_ROWS)
    ) u_out_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (out_hs),
        .mid_q(out_lane),
        .last (out_last)
    );

endmodule

// File: tb/tb_upsp_lane_dispatcher.sv
// tb_upsp_lane_dispatcher: scoreboard bench for the lane dispatcher
// in a 2-lane, 8x2 source, x4 configuration.
module tb_upsp_lane_dispatcher;

    localparam int NL = 2;
    localparam int RW = 24;
    localparam int WW = 96;
    localparam int SW = 8;
    localparam int SH = 2;
    localparam int SC = 4;
    localparam int BW = SW / NL;
    localparam int NBEATS = 64;

    typedef struct {
        int          lane;
        logic [23:0] data;
    } px_t;

    typedef struct {
        int          lane;
        logic [95:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start;
    logic             busy;
    logic             frame_done;
    logic             ac_upsp_rvalid;
    logic [RW-1:0]    ac_upsp_rdata;
    logic             upsp_ac_rready;
    logic [NL-1:0]    lane_rvalid;
    logic [NL*RW-1:0] lane_rdata;
    logic [NL-1:0]    lane_rready;
    logic [NL-1:0]    lane_wvalid;
    logic [NL*WW-1:0] lane_wdata;
    logic [NL-1:0]    lane_wready;
    logic             upsp_ac_wvalid;
    logic [WW-1:0]    upsp_ac_wdata;
    logic             ac_upsp_wready;

    int    checks = 0;
    int    errors = 0;
    int    px_acc = 0;
    int    seq[NL];
    px_t   in_q[$];
    beat_t out_q[$];

    always #5 clk = ~clk;

    upsp_lane_dispatcher #(
        .NUM_LANES         (NL),
        .UPSP_RDDATA_WIDTH (RW),
        .UPSP_WRTDATA_WIDTH(WW),
        .SRC_IMG_WIDTH     (SW),
        .SRC_IMG_HEIGHT    (SH),
        .SCALE             (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .ac_upsp_rvalid(ac_upsp_rvalid),
        .ac_upsp_rdata (ac_upsp_rdata),
        .upsp_ac_rready(upsp_ac_rready),
        .lane_rvalid   (lane_rvalid),
        .lane_rdata    (lane_rdata),
        .lane_rready   (lane_rready),
        .lane_wvalid   (lane_wvalid),
        .lane_wdata    (lane_wdata),
        .lane_wready   (lane_wready),
        .upsp_ac_wvalid(upsp_ac_wvalid),
        .upsp_ac_wdata (upsp_ac_wdata),
        .ac_upsp_wready(ac_upsp_wready)
    );

    function automatic logic [95:0] tag(input int l, input int s);
        return {32'(l), 32'hA5A5_0000, 32'(s)};
    endfunction

    task automatic set_lane_wdata();
        for (int i = 0; i < NL; i++) lane_wdata[i*WW +: WW] = tag(i, seq[i]);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic send_pixel(input int p);
        int  cyc = 0;
        bit  hs = 0;
        px_t e;
        in_q.push_back('{lane: (p % SW) / BW, data: 24'(p)});
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = 24'(p);
        while (!hs && cyc < 50) begin
            @(negedge clk);
            cyc++;
            hs = ac_upsp_rvalid && upsp_ac_rready;
            if (hs) begin
                e = in_q.pop_front();
                px_acc++;
                checks++;
                if (lane_rvalid !== 2'(1 << e.lane)) begin
                    errors++;
                    $display("FAIL route px%0d: lane_rvalid=%b want=%b",
                             p, lane_rvalid, 2'(1 << e.lane));
                end
                checks++;
                if (lane_rdata[e.lane*RW +: RW] !== e.data) begin
                    errors++;
                    $display("FAIL rdata px%0d: got=%0h want=%0h",
                             p, lane_rdata[e.lane*RW +: RW], e.data);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            errors++;
            $display("FAIL px%0d timeout: accepted=0 want=1", p);
            in_q.delete();
        end
        ac_upsp_rvalid = 1'b0;
    endtask

    task automatic drain_outputs(input int stall_at, input bit expect_done);
        int          acc = 0;
        int          cyc = 0;
        bit          hs;
        bit          stalled = 0;
        bit          inc[NL];
        logic        hold_v;
        logic [95:0] hold_d;
        beat_t       e;
        out_q.delete();
        for (int r = 0; r < SH * SC; r++)
            for (int l = 0; l < NL; l++)
                for (int c = 0; c < 4; c++)
                    out_q.push_back('{lane: l, data: tag(l, r * 4 + c)});
        for (int i = 0; i < NL; i++) seq[i] = 0;
        set_lane_wdata();
        lane_wvalid    = '1;
        ac_upsp_wready = 1'b1;
        while (acc < NBEATS && cyc < 400) begin
            if (acc == stall_at && !stalled) begin
                stalled        = 1;
                ac_upsp_wready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (k == 0) begin
                        hold_v = upsp_ac_wvalid;
                        hold_d = upsp_ac_wdata;
                        checks++;
                        if (hold_v !== 1'b1) begin
                            errors++;
                            $display("FAIL stall_valid: wvalid=%b want=1", hold_v);
                        end
                    end else begin
                        checks++;
                        if (upsp_ac_wvalid !== hold_v || upsp_ac_wdata !== hold_d) begin
                            errors++;
                            $display("FAIL stall_hold: wdata=%h want=%h",
                                     upsp_ac_wdata, hold_d);
                        end
                    end
                    checks++;
                    if (lane_wready !== 2'b00) begin
                        errors++;
                        $display("FAIL stall_wready: lane_wready=%b want=00", lane_wready);
                    end
                    @(posedge clk);
                    #1;
                end
                ac_upsp_wready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            hs = upsp_ac_wvalid && ac_upsp_wready;
            for (int i = 0; i < NL; i++) inc[i] = lane_wvalid[i] && lane_wready[i];
            if (hs) begin
                e = out_q.pop_front();
                acc++;
                checks++;
                if (upsp_ac_wdata !== e.data) begin
                    errors++;
                    $display("FAIL beat%0d data: got=%h want=%h", acc, upsp_ac_wdata, e.data);
                end
                checks++;
                if (lane_wready !== 2'(1 << e.lane)) begin
                    errors++;
                    $display("FAIL beat%0d wready: got=%b want=%b",
                             acc, lane_wready, 2'(1 << e.lane));
                end
                if (acc == NBEATS) begin
                    checks++;
                    if (busy !== 1'b1 || frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL last_beat_state: busy=%b done=%b want=1/0",
                                 busy, frame_done);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) if (inc[i]) seq[i]++;
            set_lane_wdata();
        end
        if (acc < NBEATS) begin
            errors++;
            $display("FAIL out timeout: beats=%0d want=%0d", acc, NBEATS);
        end
        checks++;
        if (expect_done) begin
            if (busy !== 1'b0 || frame_done !== 1'b1) begin
                errors++;
                $display("FAIL done_pulse: busy=%b done=%b want=0/1", busy, frame_done);
            end
            @(posedge clk);
            #1;
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL done_single: frame_done=%b want=0", frame_done);
            end
        end else begin
            if (busy !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL out_first_state: busy=%b done=%b want=1/0", busy, frame_done);
            end
            @(negedge clk);
            checks++;
            if (upsp_ac_wvalid !== 1'b0) begin
                errors++;
                $display("FAIL out_closed: wvalid=%b want=0", upsp_ac_wvalid);
            end
            @(posedge clk);
            #1;
        end
        lane_wvalid    = '0;
        ac_upsp_wready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, frame_done, upsp_ac_rready, lane_rvalid, lane_wready, upsp_ac_wvalid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got=%b want=0",
                     {busy, frame_done, upsp_ac_rready, lane_rvalid, lane_wready, upsp_ac_wvalid});
        end
        rst_n = 1'b1;
        start_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b want=1", busy);
        end
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = '0;
        lane_rready    = '1;
        lane_wvalid    = '1;
        ac_upsp_wready = 1'b1;
        @(negedge clk);
        checks++;
        if (upsp_ac_rready !== 1'b1 || upsp_ac_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_active: rready=%b wvalid=%b want=1/1",
                     upsp_ac_rready, upsp_ac_wvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, upsp_ac_rready, lane_rvalid, lane_wready, upsp_ac_wvalid} !== '0) begin
            errors++;
            $display("FAIL async_reset: got=%b want=0",
                     {busy, frame_done, upsp_ac_rready, lane_rvalid, lane_wready, upsp_ac_wvalid});
        end
        ac_upsp_rvalid = 1'b0;
        lane_wvalid    = '0;
        ac_upsp_wready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b want=0", busy);
        end
        start_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_busy: busy=%b want=1", busy);
        end
    endtask

    task automatic test_demux();
        px_acc = 0;
        for (int p = 0; p < SW * SH; p++) begin
            if (p == 4) begin
                ac_upsp_rvalid = 1'b1;
                ac_upsp_rdata  = 24'(p);
                lane_rready    = 2'b01;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checks++;
                    if (upsp_ac_rready !== 1'b0 || lane_rvalid !== 2'b10) begin
                        errors++;
                        $display("FAIL lane_stall: rready=%b lane_rvalid=%b want=0/10",
                                 upsp_ac_rready, lane_rvalid);
                    end
                    @(posedge clk);
                    #1;
                end
                lane_rready = 2'b11;
            end
            send_pixel(p);
        end
        checks++;
        if (px_acc !== SW * SH || in_q.size() != 0) begin
            errors++;
            $display("FAIL px_count: accepted=%0d want=%0d", px_acc, SW * SH);
        end
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = 24'h99;
        @(negedge clk);
        checks++;
        if (upsp_ac_rready !== 1'b0 || lane_rvalid !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL in_closed: rready=%b lane_rvalid=%b busy=%b want=0/00/1",
                     upsp_ac_rready, lane_rvalid, busy);
        end
        @(posedge clk);
        #1;
        ac_upsp_rvalid = 1'b0;
    endtask

    task automatic test_output();
        drain_outputs(10, 1'b1);
    endtask

    task automatic test_restart();
        start_frame();
        for (int p = 0; p < 6; p++) send_pixel(p);
        start_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run: busy=%b want=1", busy);
        end
        send_pixel(6);
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = 24'd7;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || lane_rvalid !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: busy=%b lane_rvalid=%b want=0/00", busy, lane_rvalid);
        end
        ac_upsp_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_frame();
        send_pixel(0);
    endtask

    task automatic test_out_first();
        drain_outputs(-1, 1'b0);
        for (int p = 1; p < SW * SH; p++) send_pixel(p);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL direct_done: done=%b busy=%b want=1/0", frame_done, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        frame_start    = 1'b0;
        ac_upsp_rvalid = 1'b0;
        ac_upsp_rdata  = '0;
        lane_rready    = '1;
        lane_wvalid    = '0;
        lane_wdata     = '0;
        ac_upsp_wready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_demux();
        test_output();
        test_restart();
        test_out_first();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
